vga_cmd_arbiter: RTL and testbench

//  Shares the single draw-command input of the VGA cell renderer between NUM_REQ command sources
//  (snake core, score display, game-over overlay). Each source pushes 32-bit commands with no

---
 rtl/vga_cmd_defs.sv | 21 ++
 rtl/cmd_fifo.sv | 44 ++++
 rtl/vga_cmd_arbiter.sv | 96 +++++++++
 tb/tb_vga_cmd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cmd_defs.sv
// Shared definitions for the VGA draw-command path: command geometry, opcodes,
// colour constants and the round-robin index helper used by the arbiter.
package vga_cmd_defs;

  localparam int unsigned CMD_WIDTH = 32;

  localparam logic [3:0] OP_CELL = 4'h0;
  localparam logic [3:0] OP_FILL = 4'h1;

  localparam logic [7:0] COLOR_PREY = 8'h3c;
  localparam logic [7:0] COLOR_HEAD = 8'h0f;
  localparam logic [7:0] COLOR_BG   = 8'hff;

  // Source index reached by stepping 'offset' places past 'base' around n sources.
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Per-source synchronous command FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_cmd_arbiter.sv
// Round-robin arbiter sharing the renderer's draw-command input between
// NUM_REQ buffered sources through a registered valid/ready output stage.
module vga_cmd_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned CMD_WIDTH  = vga_cmd_defs::CMD_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]           req_vld,
  output logic [NUM_REQ-1:0]           req_full,
  output logic [NUM_REQ-1:0]           req_ovf,
  output logic [CMD_WIDTH-1:0]         cmd,
  output logic                         cmd_vld,
  input  logic                         cmd_rdy,
  output logic [$clog2(NUM_REQ)-1:0]   cmd_src
);
  import vga_cmd_defs::*;

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   empty;
  logic [NUM_REQ-1:0]   pop;
  logic [CMD_WIDTH-1:0] head [NUM_REQ];
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     winner;
  logic [SRC_W-1:0]     scan;
  logic                 found;
  logic                 any_pending;
  logic                 load;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    cmd_fifo #(
      .WIDTH (CMD_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (req_vld[i]),
      .din   (req_cmd[i*CMD_WIDTH +: CMD_WIDTH]),
      .full  (req_full[i]),
      .rd_en (pop[i]),
      .dout  (head[i]),
      .empty (empty[i])
    );
  end

  assign any_pending = ~&empty;
  assign load        = enb & (~cmd_vld | cmd_rdy) & any_pending;

  // Scan starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    scan   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan = SRC_W'(rr_index(32'(rr_ptr), k, NUM_REQ));
      if (!found && !empty[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load) pop[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= '0;
      cmd_vld <= 1'b0;
      cmd_src <= '0;
      rr_ptr  <= SRC_W'(NUM_REQ - 1);
    end else if (load) begin
      cmd     <= head[winner];
      cmd_src <= winner;
      cmd_vld <= 1'b1;
      rr_ptr  <= winner;
    end else if (cmd_vld && cmd_rdy) begin
      cmd_vld <= 1'b0;
    end
  end

  // A push into a full FIFO survives only if that FIFO is popped in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) req_ovf <= '0;
    else     req_ovf <= req_ovf | (req_vld & req_full & ~pop);
  end

endmodule

// File: tb/tb_vga_cmd_arbiter.sv
// Directed bench for vga_cmd_arbiter with a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_vga_cmd_arbiter;

  localparam int NR = 3;
  localparam int W  = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enb = 1'b1;
  logic [NR*W-1:0] req_cmd = '0;
  logic [NR-1:0] req_vld = '0;
  logic [NR-1:0] req_full;
  logic [NR-1:0] req_ovf;
  logic [W-1:0]  cmd;
  logic          cmd_vld;
  logic          cmd_rdy = 1'b0;
  logic [1:0]    cmd_src;

  vga_cmd_arbiter #(.NUM_REQ(NR), .CMD_WIDTH(W), .FIFO_DEPTH(D), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .enb(enb), .req_cmd(req_cmd), .req_vld(req_vld),
    .req_full(req_full), .req_ovf(req_ovf), .cmd(cmd), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .cmd_src(cmd_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, a presented slot and the last grant.
  logic [31:0] mq [NR][$];
  bit          m_vld;
  logic [31:0] m_cmd;
  int          m_src;
  int          m_last;
  logic [NR-1:0] m_ovf;
  bit          m_any;
  int          m_s;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) mq[i].delete();
      m_vld = 0; m_cmd = '0; m_src = 0; m_last = NR - 1; m_ovf = '0;
    end else begin
      m_any = 0;
      for (int i = 0; i < NR; i++) if (mq[i].size() != 0) m_any = 1;
      if (enb && (!m_vld || cmd_rdy) && m_any) begin
        for (int k = 1; k <= NR; k++) begin
          m_s = (m_last + k) % NR;
          if (mq[m_s].size() != 0) begin
            m_cmd = mq[m_s].pop_front();
            m_src = m_s; m_last = m_s; m_vld = 1;
            break;
          end
        end
      end else if (m_vld && cmd_rdy) begin
        m_vld = 0;
      end
      for (int i = 0; i < NR; i++)
        if (req_vld[i]) begin
          if (mq[i].size() < D) mq[i].push_back(req_cmd[i*W +: W]);
          else m_ovf[i] = 1'b1;
        end
    end
  end

  // Accepted-command log as seen at the DUT output.
  int          acc_src [$];
  logic [31:0] acc_cmd [$];
  int          acc_cyc [$];
  logic [NR-1:0] m_full;

  always @(negedge clk) begin
    cyc++;
    if (started && !rst) begin
      for (int i = 0; i < NR; i++) m_full[i] = (mq[i].size() == D);
      chk("model_vld", 32'(cmd_vld), 32'(m_vld));
      if (m_vld) begin
        chk("model_cmd", cmd, m_cmd);
        chk("model_src", 32'(cmd_src), 32'(m_src));
      end
      chk("model_full", 32'(req_full), 32'(m_full));
      chk("model_ovf", 32'(req_ovf), 32'(m_ovf));
      if (cmd_vld === 1'b1 && cmd_rdy) begin
        acc_src.push_back(int'(cmd_src));
        acc_cmd.push_back(cmd);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_vld = '0; rst = 1'b1;
    step(); step();
    rst = 1'b0; started = 1;
  endtask

  task automatic set_push(input int s, input logic [31:0] v);
    req_vld[s] = 1'b1;
    req_cmd[s*W +: W] = v;
  endtask

  task automatic clear_log();
    acc_src.delete(); acc_cmd.delete(); acc_cyc.delete();
  endtask

  initial begin
    // 1: reset values and single-command latency
    rst = 1'b1; step(); step();
    chk("rst_vld", 32'(cmd_vld), 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_src", 32'(cmd_src), 0);
    chk("rst_full", 32'(req_full), 0);
    chk("rst_ovf", 32'(req_ovf), 0);
    rst = 1'b0; started = 1;
    set_push(1, 32'hAAAA_0001);
    step();
    req_vld = '0;
    chk("t1_not_yet", 32'(cmd_vld), 0);
    step();
    chk("t1_vld", 32'(cmd_vld), 1);
    chk("t1_cmd", cmd, 32'hAAAA_0001);
    chk("t1_src", 32'(cmd_src), 1);
    chk("t1_model_src", 32'(m_src), 1);
    cmd_rdy = 1'b1; step(); cmd_rdy = 1'b0;
    chk("t1_drained", 32'(cmd_vld), 0);

    // 2: three sources with four entries each, round-robin and bubble-free
    do_reset();
    enb = 1'b0;
    for (int n = 0; n < 4; n++) begin
      for (int s = 0; s < NR; s++) set_push(s, 32'hC0DE_0000 | (s << 8) | n);
      step();
    end
    req_vld = '0;
    chk("t2_model_depth", 32'(mq[2].size()), 4);
    clear_log();
    enb = 1'b1; cmd_rdy = 1'b1;
    for (int n = 0; n < 14; n++) step();
    cmd_rdy = 1'b0;
    chk("t2_count", 32'(acc_src.size()), 12);
    for (int k = 0; k < 12; k++)
      if (k < acc_src.size()) begin
        chk("t2_src", 32'(acc_src[k]), 32'(k % 3));
        chk("t2_cmd", acc_cmd[k], 32'hC0DE_0000 | ((k % 3) << 8) | (k / 3));
      end
    if (acc_cyc.size() == 12) chk("t2_span", 32'(acc_cyc[11] - acc_cyc[0]), 11);
    chk("t2_idle", 32'(cmd_vld), 0);

    // 3: stall with a presented command, fill src0, overflow, then drain
    do_reset();
    set_push(1, 32'h5111_0001);
    step();
    req_vld = '0;
    for (int k = 0; k < 20; k++) begin
      if (k < 9) set_push(0, 32'hD000_0000 | k);
      else req_vld = '0;
      step();
      chk("t3_hold_vld", 32'(cmd_vld), 1);
      chk("t3_hold_cmd", cmd, 32'h5111_0001);
      chk("t3_hold_src", 32'(cmd_src), 1);
      if (k == 7) begin
        chk("t3_full", 32'(req_full), 32'b001);
        chk("t3_no_ovf", 32'(req_ovf), 0);
      end
      if (k == 8) chk("t3_ovf", 32'(req_ovf), 32'b001);
    end
    req_vld = '0;
    clear_log();
    cmd_rdy = 1'b1;
    for (int n = 0; n < 12; n++) step();
    cmd_rdy = 1'b0;
    chk("t3_count", 32'(acc_src.size()), 9);
    if (acc_src.size() == 9) begin
      chk("t3_first_src", 32'(acc_src[0]), 1);
      chk("t3_first_cmd", acc_cmd[0], 32'h5111_0001);
      for (int k = 1; k < 9; k++) begin
        chk("t3_src0_src", 32'(acc_src[k]), 0);
        chk("t3_src0_cmd", acc_cmd[k], 32'hD000_0000 | (k - 1));
      end
    end
    chk("t3_ovf_sticky", 32'(req_ovf), 32'b001);

    // 4: push into full src0 in the same cycle it is popped
    do_reset();
    enb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_push(0, 32'hE000_0000 | k);
      step();
    end
    req_vld = '0;
    chk("t4_full", 32'(req_full), 32'b001);
    enb = 1'b1; cmd_rdy = 1'b1;
    set_push(0, 32'hE000_0008);
    clear_log();
    step();
    req_vld = '0;
    chk("t4_still_full", 32'(req_full), 32'b001);
    chk("t4_no_ovf", 32'(req_ovf), 0);
    for (int n = 0; n < 10; n++) step();
    cmd_rdy = 1'b0;
    chk("t4_count", 32'(acc_src.size()), 9);
    for (int k = 0; k < 9; k++)
      if (k < acc_cmd.size()) chk("t4_cmd", acc_cmd[k], 32'hE000_0000 | k);

    // 5: enb low lets the presented command finish but grants nothing new
    do_reset();
    set_push(2, 32'hF000_0002);
    set_push(0, 32'h6000_0000);
    step();
    req_vld = '0;
    step();
    chk("t5_pres_src", 32'(cmd_src), 0);
    chk("t5_pres_cmd", cmd, 32'h6000_0000);
    enb = 1'b0; cmd_rdy = 1'b1;
    clear_log();
    for (int n = 0; n < 4; n++) begin
      step();
      chk("t5_no_grant", 32'(cmd_vld), 0);
    end
    chk("t5_once", 32'(acc_src.size()), 1);
    enb = 1'b1;
    step();
    chk("t5_resume_vld", 32'(cmd_vld), 1);
    chk("t5_resume_cmd", cmd, 32'hF000_0002);
    chk("t5_resume_src", 32'(cmd_src), 2);
    step();
    cmd_rdy = 1'b0;
    chk("t5_done", 32'(cmd_vld), 0);

    // 6: reset mid-operation
    do_reset();
    enb = 1'b0;
    for (int n = 0; n < 3; n++) begin
      for (int s = 0; s < NR; s++) set_push(s, 32'h4000_0000 | (s << 8) | n);
      step();
    end
    req_vld = '0;
    for (int n = 3; n < 9; n++) begin
      set_push(1, 32'h4000_0100 | n);
      step();
    end
    req_vld = '0;
    enb = 1'b1;
    step();
    chk("t6_pres", 32'(cmd_vld), 1);
    chk("t6_ovf", 32'(req_ovf), 32'b010);
    rst = 1'b1;
    step();
    chk("t6_rst_vld", 32'(cmd_vld), 0);
    chk("t6_rst_full", 32'(req_full), 0);
    chk("t6_rst_ovf", 32'(req_ovf), 0);
    rst = 1'b0;
    for (int s = 0; s < NR; s++) set_push(s, 32'h7000_0000 | s);
    step();
    req_vld = '0;
    step();
    chk("t6_first_vld", 32'(cmd_vld), 1);
    chk("t6_first_src", 32'(cmd_src), 0);
    chk("t6_first_cmd", cmd, 32'h7000_0000);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
